// File: rtl/zstd_block_parser.sv
// Zstandard block splitter: decodes 3-byte block headers, forwards payload bytes
// two lanes per word, and collects the optional trailing content checksum.
//
// state    | meaning
// IDLE     | waiting for start after reset
// HEADER   | collecting the 3 header bytes of a block
// PAYLOAD  | forwarding block payload bytes
// CHECKSUM | collecting the 4 content checksum bytes
// DONE     | frame complete, waiting for start
// ERROR    | reserved type or oversize block, waiting for start
module zstd_block_parser #(
  parameter int BLOCK_SIZE_MAX = 131072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        start_phase,
  input  logic        checksum_present,
  input  logic [15:0] data_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic [1:0]  out_keep,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        info_valid,
  output logic        Last_Block,
  output logic [1:0]  Block_Type,
  output logic [20:0] Block_Size,
  output logic [31:0] Checksum,
  output logic        checksum_valid,
  output logic        finished,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_PAYLOAD, S_CHECKSUM, S_DONE, S_ERROR
  } state_t;

  localparam logic [31:0] SIZE_MAX = 32'(BLOCK_SIZE_MAX);

  state_t      state, nx_state;
  logic [1:0]  cnt, nx_cnt;
  logic [15:0] hdr, nx_hdr;
  logic [20:0] remaining, nx_rem;
  logic [31:0] csum_acc, nx_csum;
  logic        cp_reg, skip_hi;
  logic        accept, start_ok, eob;
  logic [7:0]  lane_byte;
  logic [23:0] h;
  logic [15:0] nx_odata;
  logic [1:0]  nx_okeep;
  logic        nx_olast;
  logic        nx_info, nx_last_blk, nx_csv;
  logic [1:0]  nx_type;
  logic [20:0] nx_size;

  assign accept   = in_valid && in_ready;
  assign start_ok = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nx_state;
  end

  // Both lanes are walked in order; a state change after the hi byte governs the lo byte.
  always_comb begin
    nx_state    = state;
    nx_cnt      = cnt;
    nx_hdr      = hdr;
    nx_rem      = remaining;
    nx_csum     = csum_acc;
    nx_odata    = 16'h0000;
    nx_okeep    = 2'b00;
    nx_olast    = 1'b0;
    nx_info     = 1'b0;
    nx_last_blk = Last_Block;
    nx_type     = Block_Type;
    nx_size     = Block_Size;
    nx_csv      = 1'b0;
    lane_byte   = 8'h00;
    h           = 24'h000000;
    eob         = 1'b0;
    if (accept) begin
      for (int i = 0; i < 2; i++) begin
        lane_byte = (i == 0) ? data_in[15:8] : data_in[7:0];
        eob       = 1'b0;
        if (!(i == 0 && skip_hi)) begin
          case (nx_state)
            S_HEADER: begin
              if (nx_cnt == 2'd2) begin
                h           = {lane_byte, nx_hdr};
                nx_info     = 1'b1;
                nx_last_blk = h[0];
                nx_type     = h[2:1];
                nx_size     = h[23:3];
                nx_cnt      = 2'd0;
                if (h[2:1] == 2'd3 || {11'd0, h[23:3]} > SIZE_MAX) begin
                  nx_state = S_ERROR;
                end else if (h[2:1] == 2'd1) begin
                  nx_state = S_PAYLOAD;
                  nx_rem   = 21'd1;
                end else if (h[23:3] == 21'd0) begin
                  eob = 1'b1;
                end else begin
                  nx_state = S_PAYLOAD;
                  nx_rem   = h[23:3];
                end
              end else begin
                if (nx_cnt == 2'd0) nx_hdr[7:0]  = lane_byte;
                else                nx_hdr[15:8] = lane_byte;
                nx_cnt = nx_cnt + 2'd1;
              end
            end
            S_PAYLOAD: begin
              if (nx_okeep == 2'b00) begin
                nx_odata[15:8] = lane_byte;
                nx_okeep       = 2'b10;
              end else begin
                nx_odata[7:0] = lane_byte;
                nx_okeep      = 2'b11;
              end
              nx_rem = nx_rem - 21'd1;
              if (nx_rem == 21'd0) begin
                nx_olast = 1'b1;
                eob      = 1'b1;
              end
            end
            S_CHECKSUM: begin
              nx_csum = {lane_byte, nx_csum[31:8]};
              if (nx_cnt == 2'd3) begin
                nx_csv   = 1'b1;
                nx_state = S_DONE;
              end else begin
                nx_cnt = nx_cnt + 2'd1;
              end
            end
            default: ;
          endcase
          if (eob) begin
            nx_cnt = 2'd0;
            if (!nx_last_blk)  nx_state = S_HEADER;
            else if (cp_reg)   nx_state = S_CHECKSUM;
            else               nx_state = S_DONE;
          end
        end
      end
    end
    if (start_ok) begin
      nx_state = S_HEADER;
      nx_cnt   = 2'd0;
    end
  end

  always_comb begin
    in_ready = (state == S_HEADER || state == S_PAYLOAD || state == S_CHECKSUM) &&
               (!out_valid || out_ready);
    finished = (state == S_DONE);
    error    = (state == S_ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt            <= 2'd0;
      hdr            <= 16'h0000;
      remaining      <= 21'd0;
      csum_acc       <= 32'h0;
      cp_reg         <= 1'b0;
      skip_hi        <= 1'b0;
      info_valid     <= 1'b0;
      Last_Block     <= 1'b0;
      Block_Type     <= 2'd0;
      Block_Size     <= 21'd0;
      Checksum       <= 32'h0;
      checksum_valid <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= 16'h0000;
      out_keep       <= 2'b00;
      out_last       <= 1'b0;
    end else begin
      cnt            <= nx_cnt;
      hdr            <= nx_hdr;
      remaining      <= nx_rem;
      csum_acc       <= nx_csum;
      info_valid     <= nx_info;
      checksum_valid <= nx_csv;
      if (nx_info) begin
        Last_Block <= nx_last_blk;
        Block_Type <= nx_type;
        Block_Size <= nx_size;
      end
      if (nx_csv) Checksum <= nx_csum;
      if (accept) skip_hi <= 1'b0;
      if (start_ok) begin
        cp_reg  <= checksum_present;
        skip_hi <= start_phase;
      end
      if (accept && nx_okeep != 2'b00) begin
        out_valid <= 1'b1;
        out_data  <= nx_odata;
        out_keep  <= nx_okeep;
        out_last  <= nx_olast;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zstd_block_parser.sv
// Scoreboard bench for zstd_block_parser: expected payload words, header decodes
// and checksums are queued as stimulus is driven and popped as the DUT emits them.
module tb_zstd_block_parser;

  logic        clk = 1'b0;
  logic        reset, start, start_phase, checksum_present;
  logic [15:0] data_in;
  logic        in_valid, in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_keep;
  logic        out_valid, out_ready, out_last;
  logic        info_valid, Last_Block;
  logic [1:0]  Block_Type;
  logic [20:0] Block_Size;
  logic [31:0] Checksum;
  logic        checksum_valid, finished, error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [18:0] out_q[$];
  logic [23:0] info_q[$];
  logic [31:0] cs_q[$];

  zstd_block_parser #(.BLOCK_SIZE_MAX(131072)) dut (
    .clk(clk), .reset(reset), .start(start), .start_phase(start_phase),
    .checksum_present(checksum_present), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_keep(out_keep),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .info_valid(info_valid), .Last_Block(Last_Block), .Block_Type(Block_Type),
    .Block_Size(Block_Size), .Checksum(Checksum), .checksum_valid(checksum_valid),
    .finished(finished), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic exp_out(input logic [15:0] d, input logic [1:0] k, input logic l);
    out_q.push_back({d, k, l});
  endtask

  task automatic exp_info(input logic l, input logic [1:0] t, input logic [20:0] s);
    info_q.push_back({l, t, s});
  endtask

  task automatic send(input logic [15:0] w);
    int t;
    t = 0;
    data_in  = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_start(input logic p, input logic c);
    start            = 1'b1;
    start_phase      = p;
    checksum_present = c;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},   32'(in_ready), 32'd0);
    check({tag, "_out_valid"},  32'(out_valid), 32'd0);
    check({tag, "_out_keep"},   32'(out_keep), 32'd0);
    check({tag, "_out_data"},   32'(out_data), 32'd0);
    check({tag, "_out_last"},   32'(out_last), 32'd0);
    check({tag, "_info_valid"}, 32'(info_valid), 32'd0);
    check({tag, "_last_block"}, 32'(Last_Block), 32'd0);
    check({tag, "_block_type"}, 32'(Block_Type), 32'd0);
    check({tag, "_block_size"}, 32'(Block_Size), 32'd0);
    check({tag, "_checksum"},   Checksum, 32'd0);
    check({tag, "_cs_valid"},   32'(checksum_valid), 32'd0);
    check({tag, "_finished"},   32'(finished), 32'd0);
    check({tag, "_error"},      32'(error), 32'd0);
  endtask

  // Monitor: pop the scoreboards whenever the DUT presents a result.
  always @(negedge clk) begin
    logic [18:0] e;
    logic [23:0] ei;
    logic [15:0] m;
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (out_q.size() == 0) check("out_unexpected", 32'(out_data), 32'hFFFF_FFFF);
        else begin
          e = out_q.pop_front();
          m = e[1] ? 16'hFFFF : 16'hFF00;
          check("out_data", 32'(out_data & m), 32'(e[18:3]));
          check("out_keep", 32'(out_keep), 32'(e[2:1]));
          check("out_last", 32'(out_last), 32'(e[0]));
        end
      end
      if (info_valid) begin
        if (info_q.size() == 0) check("info_unexpected", 32'(Block_Size), 32'hFFFF_FFFF);
        else begin
          ei = info_q.pop_front();
          check("info_last", 32'(Last_Block), 32'(ei[23]));
          check("info_type", 32'(Block_Type), 32'(ei[22:21]));
          check("info_size", 32'(Block_Size), 32'(ei[20:0]));
        end
      end
      if (checksum_valid) begin
        if (cs_q.size() == 0) check("cs_unexpected", Checksum, 32'hDEAD_BEEF);
        else check("checksum", Checksum, cs_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; start_phase = 1'b0; checksum_present = 1'b0;
    data_in = 16'h0000; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check_reset("rst0");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    idle(1);

    // Raw block, Last=1, Size=4
    do_start(1'b0, 1'b0);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    exp_info(1'b1, 2'd0, 21'd4);
    exp_out(16'hAA00, 2'b10, 1'b0);
    exp_out(16'hBBCC, 2'b11, 1'b0);
    exp_out(16'hDD00, 2'b10, 1'b1);
    send(16'h2100);
    send(16'h00AA);
    check("t1_info_pulse", 32'(info_valid), 32'd1);
    send(16'hBBCC);
    check("t1_not_finished", 32'(finished), 32'd0);
    send(16'hDDEE);
    check("t1_finished", 32'(finished), 32'd1);
    idle(3);

    // RLE Size=1000 Last=0, then Raw Size=0 Last=1
    do_start(1'b0, 1'b0);
    check("t2_finished_clr", 32'(finished), 32'd0);
    exp_info(1'b0, 2'd1, 21'd1000);
    exp_out(16'h5A00, 2'b10, 1'b1);
    exp_info(1'b1, 2'd0, 21'd0);
    send(16'h421F);
    send(16'h005A);
    send(16'h0100);
    send(16'h0099);
    check("t2_finished", 32'(finished), 32'd1);
    idle(3);

    // Checksum present
    do_start(1'b0, 1'b1);
    exp_info(1'b1, 2'd0, 21'd2);
    exp_out(16'hE100, 2'b10, 1'b0);
    exp_out(16'hE200, 2'b10, 1'b1);
    cs_q.push_back(32'h1234_5678);
    send(16'h1100);
    send(16'h00E1);
    send(16'hE278);
    send(16'h5634);
    check("t3_no_finish_yet", 32'(finished), 32'd0);
    send(16'h12FF);
    check("t3_cs_pulse", 32'(checksum_valid), 32'd1);
    check("t3_cs_value", Checksum, 32'h1234_5678);
    check("t3_finished", 32'(finished), 32'd1);
    idle(1);
    check("t3_cs_single", 32'(checksum_valid), 32'd0);
    idle(2);

    // Reserved block type
    do_start(1'b0, 1'b0);
    exp_info(1'b0, 2'd3, 21'd0);
    send(16'h0600);
    send(16'h00EE);
    check("t4_error", 32'(error), 32'd1);
    check("t4_in_ready", 32'(in_ready), 32'd0);
    idle(2);
    check("t4_error_sticky", 32'(error), 32'd1);
    do_start(1'b0, 1'b0);
    check("t4_error_clr", 32'(error), 32'd0);
    check("t4_in_ready_back", 32'(in_ready), 32'd1);

    // Oversize block
    exp_info(1'b0, 2'd0, 21'd131073);
    send(16'h0800);
    send(16'h1033);
    check("t5_error", 32'(error), 32'd1);
    do_start(1'b0, 1'b0);
    check("t5_error_clr", 32'(error), 32'd0);

    // Size exactly at the limit is legal (RLE, Last=1)
    exp_info(1'b1, 2'd1, 21'd131072);
    exp_out(16'h7700, 2'b10, 1'b1);
    send(16'h0300);
    send(16'h1077);
    check("t5_max_no_error", 32'(error), 32'd0);
    check("t5_max_finished", 32'(finished), 32'd1);
    idle(3);

    // Backpressure mid-payload
    do_start(1'b0, 1'b0);
    exp_info(1'b1, 2'd0, 21'd8);
    exp_out(16'h0100, 2'b10, 1'b0);
    exp_out(16'h0203, 2'b11, 1'b0);
    exp_out(16'h0405, 2'b11, 1'b0);
    exp_out(16'h0607, 2'b11, 1'b0);
    exp_out(16'h0800, 2'b10, 1'b1);
    send(16'h4100);
    send(16'h0001);
    send(16'h0203);
    out_ready = 1'b0;
    data_in   = 16'h0405;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_bp_in_ready", 32'(in_ready), 32'd0);
      check("t6_bp_data", 32'(out_data), 32'h0203);
      check("t6_bp_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'h0405);
    send(16'h0607);
    send(16'h08AA);
    check("t6_finished", 32'(finished), 32'd1);
    idle(3);

    // start_phase=1, header split lo/hi/lo
    do_start(1'b1, 1'b0);
    exp_info(1'b1, 2'd0, 21'd3);
    exp_out(16'hC1C2, 2'b11, 1'b0);
    exp_out(16'hC300, 2'b10, 1'b1);
    send(16'hEE19);
    send(16'h0000);
    check("t7_info_pulse", 32'(info_valid), 32'd1);
    send(16'hC1C2);
    send(16'hC3DD);
    check("t7_finished", 32'(finished), 32'd1);
    idle(3);

    // Reset mid-payload
    do_start(1'b0, 1'b0);
    exp_info(1'b0, 2'd0, 21'd10);
    exp_out(16'hAB00, 2'b10, 1'b0);
    send(16'h5000);
    send(16'h00AB);
    idle(1);
    send(16'hCDEF);
    check("t8_valid_before_rst", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check_reset("t8_rst");
    @(negedge clk) reset = 1'b0;
    idle(2);
    check("t8_idle_in_ready", 32'(in_ready), 32'd0);

    check("out_q_empty",  32'(out_q.size()), 32'd0);
    check("info_q_empty", 32'(info_q.size()), 32'd0);
    check("cs_q_empty",   32'(cs_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
